// File: rtl/sig_burst_gen.sv
// -----------------------------------------------------------------------------
// sig_burst_gen
//
// Programmable rectangular-waveform generator. A start request in IDLE latches
// period / high_time / burst into shadow registers and the block transmits
// periods of `period_r` clk cycles, the first `high_r` of which are high. It
// either stops after `burst_r` periods or runs continuously (burst = 0) until
// a graceful stop request, which takes effect at the next period boundary.
// The shadow period/high registers reload from the live inputs only at period
// boundaries, so waveform updates never glitch mid-period.
//
// Optional build macro: SIG_GEN_COMP_OUT_EN
//   When defined, adds a registered complementary output sig_out_n that is
//   high only inside the low phase, with DEAD_CYCLES guard cycles on both
//   sides of the high phase.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start        start request, sampled only in IDLE
//   stop         graceful stop request, sampled only in RUN
//   period       period in clk cycles (values < 2 are rejected)
//   high_time    high cycles per period (>= period gives 100 %, 0 gives 0 %)
//   burst        periods to send, 0 = continuous
//   busy         high while generating
//   finish       one-cycle pulse when generation ends (with busy falling)
//   cycle_done   high during the last cycle of each period
//   cycles_sent  periods completed since the last start (wraps)
//   sig_out      generated waveform, registered
//   sig_out_n    complementary waveform with dead time (optional)
// -----------------------------------------------------------------------------
module sig_burst_gen #(
  parameter int CNT_W       = 20,
  parameter int BURST_W     = 8,
  parameter int DEAD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   high_time,
  input  logic [BURST_W-1:0] burst,
  output logic               busy,
  output logic               finish,
  output logic               cycle_done,
  output logic [BURST_W-1:0] cycles_sent,
`ifdef SIG_GEN_COMP_OUT_EN
  output logic               sig_out_n,
`endif
  output logic               sig_out
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_r_q, period_r_d;
  logic [CNT_W-1:0]   high_r_q, high_r_d;
  logic [BURST_W-1:0] burst_r_q, burst_r_d;
  logic [BURST_W-1:0] cycles_sent_q, cycles_sent_d;
  logic               stop_latch_q, stop_latch_d;
  logic               sig_out_q, sig_out_d;
  logic               finish_q, finish_d;

  logic               period_ok;
  logic               at_boundary;
  logic [BURST_W-1:0] sent_inc;
  logic               end_run;

  assign period_ok   = (period >= CNT_W'(2));
  assign at_boundary = (state_q == RUN) && (cnt_q == (period_r_q - CNT_W'(1)));
  assign sent_inc    = cycles_sent_q + BURST_W'(1);
  assign end_run     = ((burst_r_q != '0) && (sent_inc == burst_r_q)) || stop_latch_q;

  // Next-state logic. sig_out_d is computed from the cycle position that the
  // counter will hold next, so the registered waveform lines up with cnt_q.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    period_r_d    = period_r_q;
    high_r_d      = high_r_q;
    burst_r_d     = burst_r_q;
    cycles_sent_d = cycles_sent_q;
    stop_latch_d  = stop_latch_q;
    sig_out_d     = sig_out_q;
    finish_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && period_ok) begin
          state_d       = RUN;
          period_r_d    = period;
          high_r_d      = high_time;
          burst_r_d     = burst;
          cnt_d         = '0;
          cycles_sent_d = '0;
          stop_latch_d  = 1'b0;
          sig_out_d     = (high_time != '0);
        end
      end

      RUN: begin
        if (stop) begin
          stop_latch_d = 1'b1;
        end
        if (at_boundary) begin
          cycles_sent_d = sent_inc;
          cnt_d         = '0;
          if (end_run) begin
            state_d      = IDLE;
            finish_d     = 1'b1;
            sig_out_d    = 1'b0;
            stop_latch_d = 1'b0;
          end else begin
            // An out-of-range live period keeps the old period and high time
            // together so the pair stays consistent.
            if (period_ok) begin
              period_r_d = period;
              high_r_d   = high_time;
            end
            sig_out_d = (high_r_d != '0);
          end
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          sig_out_d = (({1'b0, cnt_q} + (CNT_W+1)'(1)) < {1'b0, high_r_q});
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SIG_GEN_COMP_OUT_EN
  localparam int EXT_W = CNT_W + 2;

  logic sig_out_n_q, sig_out_n_d;

  // Complementary window high_r+DEAD <= cnt <= period_r-1-DEAD, evaluated on
  // the next-cycle values and rearranged to avoid any unsigned underflow.
  always_comb begin
    sig_out_n_d = 1'b0;
    if (state_d == RUN) begin
      sig_out_n_d = ({2'b00, cnt_d} >= ({2'b00, high_r_d} + EXT_W'(DEAD_CYCLES))) &&
                    (({2'b00, cnt_d} + EXT_W'(1) + EXT_W'(DEAD_CYCLES)) <= {2'b00, period_r_d});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_out_n_q <= 1'b0;
    end else begin
      sig_out_n_q <= sig_out_n_d;
    end
  end

  assign sig_out_n = sig_out_n_q;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      period_r_q    <= '0;
      high_r_q      <= '0;
      burst_r_q     <= '0;
      cycles_sent_q <= '0;
      stop_latch_q  <= 1'b0;
      sig_out_q     <= 1'b0;
      finish_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      period_r_q    <= period_r_d;
      high_r_q      <= high_r_d;
      burst_r_q     <= burst_r_d;
      cycles_sent_q <= cycles_sent_d;
      stop_latch_q  <= stop_latch_d;
      sig_out_q     <= sig_out_d;
      finish_q      <= finish_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign finish      = finish_q;
  assign cycle_done  = at_boundary;
  assign cycles_sent = cycles_sent_q;
  assign sig_out     = sig_out_q;

endmodule

// File: tb/tb_sig_burst_gen.sv
// -----------------------------------------------------------------------------
// tb_sig_burst_gen
//
// Self-checking bench for sig_burst_gen. A transaction-level reference model
// tracks the position inside the current period and derives every output from
// it each cycle; directed scenarios additionally check whole-burst totals
// (busy length, high cycles, period lengths, finish pulses).
// -----------------------------------------------------------------------------
module tb_sig_burst_gen;

  localparam int CNT_W   = 20;
  localparam int BURST_W = 8;
  localparam int DEAD    = 2;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic [CNT_W-1:0]   period;
  logic [CNT_W-1:0]   high_time;
  logic [BURST_W-1:0] burst;
  logic               busy;
  logic               finish;
  logic               cycle_done;
  logic [BURST_W-1:0] cycles_sent;
  logic               sig_out;
`ifdef SIG_GEN_COMP_OUT_EN
  logic               sig_out_n;
`endif

  int test_count = 0;
  int fail_count = 0;
  bit chk_en     = 1'b0;

  int cd_pos[0:15];
  int cd_n;

  sig_burst_gen #(
    .CNT_W      (CNT_W),
    .BURST_W    (BURST_W),
    .DEAD_CYCLES(DEAD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .period     (period),
    .high_time  (high_time),
    .burst      (burst),
    .busy       (busy),
    .finish     (finish),
    .cycle_done (cycle_done),
    .cycles_sent(cycles_sent),
`ifdef SIG_GEN_COMP_OUT_EN
    .sig_out_n  (sig_out_n),
`endif
    .sig_out    (sig_out)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a generation run is described by the position inside the
  // current period plus the period/high/burst in force; outputs follow from
  // the rule "high while position < high time".
  bit               m_run;
  int               m_pos;
  int               m_per;
  int               m_high;
  int               m_burst;
  int               m_sent;
  bit               m_stop;
  bit               m_finish;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_pos = 0; m_per = 0; m_high = 0;
      m_burst = 0; m_sent = 0; m_stop = 0; m_finish = 0;
    end else begin
      m_finish = 0;
      if (!m_run) begin
        if (start && int'(period) >= 2) begin
          m_run   = 1;
          m_per   = int'(period);
          m_high  = int'(high_time);
          m_burst = int'(burst);
          m_pos   = 0;
          m_sent  = 0;
          m_stop  = 0;
        end
      end else begin
        if (m_pos == m_per - 1) begin
          m_sent = (m_sent + 1) % 256;
          m_pos  = 0;
          if ((m_burst != 0 && m_sent == m_burst) || m_stop) begin
            m_run    = 0;
            m_finish = 1;
          end else if (int'(period) >= 2) begin
            m_per  = int'(period);
            m_high = int'(high_time);
          end
        end else begin
          m_pos = m_pos + 1;
        end
        if (stop && m_run) m_stop = 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("busy", 32'(busy), 32'(m_run));
      checkOutput("finish", 32'(finish), 32'(m_finish));
      checkOutput("cycle_done", 32'(cycle_done), 32'(m_run && (m_pos == m_per - 1)));
      checkOutput("cycles_sent", 32'(cycles_sent), 32'(m_sent));
      checkOutput("sig_out", 32'(sig_out), 32'(m_run && (m_pos < m_high)));
`ifdef SIG_GEN_COMP_OUT_EN
      checkOutput("sig_out_n", 32'(sig_out_n),
                  32'(m_run && (m_pos >= m_high + DEAD) && (m_pos <= m_per - 1 - DEAD)));
`endif
    end
  end

  // Load a configuration and present start for exactly one rising edge.
  task automatic applyStimulus(input int per, input int high, input int bst);
    @(negedge clk);
    period    = CNT_W'(per);
    high_time = CNT_W'(high);
    burst     = BURST_W'(bst);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Follow a run until busy drops, optionally pulsing stop or changing the
  // live period at given busy-cycle indices (1-based, 0 = never).
  task automatic runToEnd(input int stop_at, input int chg1_at, input int chg1_per,
                          input int chg2_at, input int chg2_per,
                          output int busy_cycles, output int hi_cycles, output int fin_pulses);
    int guard;
    busy_cycles = 0;
    hi_cycles   = 0;
    fin_pulses  = 0;
    cd_n        = 0;
    guard       = 0;
    while (busy && guard < 2000) begin
      busy_cycles++;
      if (sig_out) hi_cycles++;
      if (finish) fin_pulses++;
      if (cycle_done && cd_n < 16) begin
        cd_pos[cd_n] = busy_cycles;
        cd_n++;
      end
      stop = (busy_cycles == stop_at);
      if (busy_cycles == chg1_at) period = CNT_W'(chg1_per);
      if (busy_cycles == chg2_at) period = CNT_W'(chg2_per);
      @(negedge clk);
      guard++;
    end
    stop = 1'b0;
    if (guard >= 2000) checkOutput("run_timeout", 32'd1, 32'd0);
    if (finish) fin_pulses++;
  endtask

  initial begin
    int bc, hc, fp;
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    period    = '0;
    high_time = '0;
    burst     = '0;

    // Reset state
    #12;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_finish", 32'(finish), 32'd0);
    checkOutput("rst_cycle_done", 32'(cycle_done), 32'd0);
    checkOutput("rst_cycles_sent", 32'(cycles_sent), 32'd0);
    checkOutput("rst_sig_out", 32'(sig_out), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    // Burst of 4 periods, 3 high / 7 low
    applyStimulus(10, 3, 4);
    runToEnd(0, 0, 0, 0, 0, bc, hc, fp);
    checkOutput("b4_busy_len", 32'(bc), 32'd40);
    checkOutput("b4_high_cycles", 32'(hc), 32'd12);
    checkOutput("b4_cycle_done_cnt", 32'(cd_n), 32'd4);
    checkOutput("b4_finish_pulses", 32'(fp), 32'd1);
    checkOutput("b4_cycles_sent", 32'(cycles_sent), 32'd4);
    @(negedge clk);
    checkOutput("b4_finish_drop", 32'(finish), 32'd0);

    // Continuous run stopped mid period 3
    applyStimulus(8, 4, 0);
    runToEnd(19, 0, 0, 0, 0, bc, hc, fp);
    checkOutput("stop_busy_len", 32'(bc), 32'd24);
    checkOutput("stop_cycles_sent", 32'(cycles_sent), 32'd3);
    checkOutput("stop_finish_pulses", 32'(fp), 32'd1);

    // 100 % and 0 % duty
    applyStimulus(5, 5, 2);
    runToEnd(0, 0, 0, 0, 0, bc, hc, fp);
    checkOutput("full_busy_len", 32'(bc), 32'd10);
    checkOutput("full_high_cycles", 32'(hc), 32'd10);
    applyStimulus(5, 0, 2);
    runToEnd(0, 0, 0, 0, 0, bc, hc, fp);
    checkOutput("zero_busy_len", 32'(bc), 32'd10);
    checkOutput("zero_high_cycles", 32'(hc), 32'd0);

    // period = 1 is rejected
    applyStimulus(1, 1, 3);
    checkOutput("p1_busy_now", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("p1_busy_later", 32'(busy), 32'd0);

    // Period change 10 -> 20 mid period, then an ignored change to 1
    applyStimulus(10, 3, 0);
    runToEnd(35, 5, 20, 15, 1, bc, hc, fp);
    checkOutput("chg_first_boundary", 32'(cd_pos[0]), 32'd10);
    checkOutput("chg_second_boundary", 32'(cd_pos[1]), 32'd30);
    checkOutput("chg_third_boundary", 32'(cd_pos[2]), 32'd50);
    checkOutput("chg_busy_len", 32'(bc), 32'd50);
    checkOutput("chg_cycles_sent", 32'(cycles_sent), 32'd3);

    // Stop and burst end on the same boundary give one finish
    applyStimulus(4, 1, 3);
    runToEnd(10, 0, 0, 0, 0, bc, hc, fp);
    checkOutput("same_busy_len", 32'(bc), 32'd12);
    checkOutput("same_finish_pulses", 32'(fp), 32'd1);

    // cycles_sent wraps after 256 periods
    applyStimulus(2, 1, 0);
    runToEnd(511, 0, 0, 0, 0, bc, hc, fp);
    checkOutput("wrap_busy_len", 32'(bc), 32'd512);
    checkOutput("wrap_cycles_sent", 32'(cycles_sent), 32'd0);

    // Reset in the middle of a burst
    applyStimulus(10, 3, 4);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_finish", 32'(finish), 32'd0);
    checkOutput("mid_rst_sig_out", 32'(sig_out), 32'd0);
    checkOutput("mid_rst_cycles_sent", 32'(cycles_sent), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_finish", 32'(finish), 32'd0);

    // Randomized transactions with live reconfiguration and stops
    for (int t = 0; t < 40; t++) begin
      int per, hi, bst, guard;
      per = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 12));
      hi  = int'($urandom_range(0, 14));
      bst = int'($urandom_range(0, 4));
      applyStimulus(per, hi, bst);
      guard = 0;
      while (busy && guard < 400) begin
        stop  = ($urandom_range(0, 39) == 0) || (guard > 60);
        start = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 7) == 0) begin
          period    = ($urandom_range(0, 5) == 0) ? CNT_W'($urandom_range(0, 1))
                                                  : CNT_W'($urandom_range(2, 12));
          high_time = CNT_W'($urandom_range(0, 14));
        end
        @(negedge clk);
        guard++;
      end
      stop  = 1'b0;
      start = 1'b0;
      if (guard >= 400) checkOutput("rand_timeout", 32'd1, 32'd0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
